// File: rtl/cnt_seq_checker.sv
// Monitors a slow modulo counter: checks step legality and per-value dwell time,
// reports registered event pulses and keeps wrap and error tallies.
module cnt_seq_checker #(
  parameter int DWELL  = 5,
  parameter int MAXVAL = 2,
  parameter int ERRW   = 8,
  parameter int WRAPW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cnt_in,
  input  logic             clr_err,
  output logic             step,
  output logic             wrap,
  output logic             seq_err,
  output logic             dwell_err,
  output logic             locked,
  output logic [ERRW-1:0]  err_cnt,
  output logic [WRAPW-1:0] wrap_cnt
);

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

  localparam logic [1:0]      MAXV    = 2'(MAXVAL);
  localparam logic [7:0]      DWELL_V = 8'(DWELL);
  localparam logic [ERRW-1:0] ERR_MAX = '1;

  state_t     state, state_n;
  logic [1:0] p_cnt;
  logic [1:0] nxt;
  logic [7:0] dcnt;
  logic       change, legal, dwell_ok;
  logic       wrap_n, seq_n, dwell_n;

  assign change   = (cnt_in != p_cnt);
  assign nxt      = (p_cnt == MAXV) ? 2'd0 : p_cnt + 2'd1;
  assign legal    = (cnt_in == nxt) && ({1'b0, cnt_in} <= {1'b0, MAXV});
  assign dwell_ok = (dcnt == DWELL_V);
  assign locked   = (state == LOCKED);

  // dcnt holds the dwell of the current value at the moment it is left;
  // seq_err wins the next-state choice when both errors fire in LOCKED.
  always_comb begin
    state_n = state;
    wrap_n  = 1'b0;
    seq_n   = 1'b0;
    dwell_n = 1'b0;
    case (state)
      IDLE: begin
        if (change) begin
          if (legal) state_n = SYNC;
          else       seq_n   = 1'b1;
        end
      end
      SYNC: begin
        if (change) begin
          if (!legal) begin
            seq_n   = 1'b1;
            state_n = IDLE;
          end else if (dwell_ok) begin
            state_n = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (change) begin
          if (!legal) begin
            seq_n   = 1'b1;
            dwell_n = !dwell_ok;
            state_n = IDLE;
          end else if (!dwell_ok) begin
            dwell_n = 1'b1;
            state_n = SYNC;
          end else begin
            wrap_n = (p_cnt == MAXV);
          end
        end else if (dwell_ok) begin
          dwell_n = 1'b1;
          state_n = SYNC;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      p_cnt     <= 2'd0;
      dcnt      <= 8'd0;
      step      <= 1'b0;
      wrap      <= 1'b0;
      seq_err   <= 1'b0;
      dwell_err <= 1'b0;
      err_cnt   <= '0;
      wrap_cnt  <= '0;
    end else begin
      state     <= state_n;
      p_cnt     <= cnt_in;
      step      <= change;
      wrap      <= wrap_n;
      seq_err   <= seq_n;
      dwell_err <= dwell_n;
      if (change)
        dcnt <= 8'd1;
      else if (dcnt != 8'hFF)
        dcnt <= dcnt + 8'd1;
      // A simultaneous seq/dwell error is one event; clear beats increment.
      if (clr_err)
        err_cnt <= '0;
      else if ((seq_n || dwell_n) && (err_cnt != ERR_MAX))
        err_cnt <= err_cnt + 1'b1;
      if (wrap_n)
        wrap_cnt <= wrap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker (DWELL=5, MAXVAL=2): clean sequence, jump,
// short dwell, stall, range, simultaneous errors, saturation and mid-run reset.
module tb_cnt_seq_checker;

  logic       clk;
  logic       rst;
  logic [1:0] cnt_in;
  logic       clr_err;
  logic       step, wrap, seq_err, dwell_err, locked;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;

  int n_pass  = 0;
  int n_total = 0;

  cnt_seq_checker #(.DWELL(5), .MAXVAL(2), .ERRW(8), .WRAPW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .clr_err   (clr_err),
    .step      (step),
    .wrap      (wrap),
    .seq_err   (seq_err),
    .dwell_err (dwell_err),
    .locked    (locked),
    .err_cnt   (err_cnt),
    .wrap_cnt  (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one value for n clock edges; outputs are sampled 1 time unit after the last edge.
  task automatic apply_stimulus(input logic [1:0] v, input int n);
    cnt_in = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_field(input string tag, input string field,
                             input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s.%s: observed %0d, expected %0d", tag, field, obs, exp);
  endtask

  task automatic check_output(input string tag, input logic e_step, input logic e_wrap,
                              input logic e_seq, input logic e_dwell, input logic e_locked,
                              input int e_err, input int e_wrapc);
    check_field(tag, "step",      {31'd0, step},      {31'd0, e_step});
    check_field(tag, "wrap",      {31'd0, wrap},      {31'd0, e_wrap});
    check_field(tag, "seq_err",   {31'd0, seq_err},   {31'd0, e_seq});
    check_field(tag, "dwell_err", {31'd0, dwell_err}, {31'd0, e_dwell});
    check_field(tag, "locked",    {31'd0, locked},    {31'd0, e_locked});
    check_field(tag, "err_cnt",   {24'd0, err_cnt},   32'(e_err));
    check_field(tag, "wrap_cnt",  {24'd0, wrap_cnt},  32'(e_wrapc));
  endtask

  initial begin
    rst     = 1'b0;
    cnt_in  = 2'd0;
    clr_err = 1'b0;
    tick();
    tick();
    check_output("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // Clean sequence: IDLE -> SYNC on 0->1, LOCKED on 1->2.
    apply_stimulus(2'd0, 5);
    check_output("idle_hold", 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(2'd1, 1);
    check_output("first_step", 1, 0, 0, 0, 0, 0, 0);
    apply_stimulus(2'd1, 4);
    check_output("sync_hold", 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(2'd2, 1);
    check_output("lock", 1, 0, 0, 0, 1, 0, 0);
    apply_stimulus(2'd2, 4);

    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(2'd0, 1);
      check_output("wrap", 1, 1, 0, 0, 1, 0, k);
      apply_stimulus(2'd0, 1);
      check_output("wrap_drop", 0, 0, 0, 0, 1, 0, k);
      apply_stimulus(2'd0, 3);
      apply_stimulus(2'd1, 5);
      apply_stimulus(2'd2, 5);
    end

    // Jump 0->2 after a full dwell: seq_err only.
    apply_stimulus(2'd0, 5);
    check_output("pre_jump", 0, 0, 0, 0, 1, 0, 5);
    apply_stimulus(2'd2, 1);
    check_output("jump", 1, 0, 1, 0, 0, 1, 5);

    // Relock from IDLE, then short dwell on value 1.
    apply_stimulus(2'd2, 4);
    apply_stimulus(2'd0, 1);
    check_output("resync", 1, 0, 0, 0, 0, 1, 5);
    apply_stimulus(2'd0, 4);
    apply_stimulus(2'd1, 1);
    check_output("relock", 1, 0, 0, 0, 1, 1, 5);
    apply_stimulus(2'd1, 3);
    apply_stimulus(2'd2, 1);
    check_output("short_dwell", 1, 0, 0, 1, 0, 2, 5);
    apply_stimulus(2'd2, 4);
    apply_stimulus(2'd0, 1);
    check_output("locked_again", 1, 0, 0, 0, 1, 2, 5);
    apply_stimulus(2'd0, 4);
    apply_stimulus(2'd1, 1);
    check_output("locked_stay", 1, 0, 0, 0, 1, 2, 5);

    // Stall on value 1: one dwell_err when the sixth sample of the same value arrives.
    apply_stimulus(2'd1, 3);
    apply_stimulus(2'd1, 1);
    check_output("stall_pre", 0, 0, 0, 0, 1, 2, 5);
    apply_stimulus(2'd1, 1);
    check_output("stall", 0, 0, 0, 1, 0, 3, 5);
    apply_stimulus(2'd1, 1);
    check_output("stall_quiet", 0, 0, 0, 0, 0, 3, 5);
    apply_stimulus(2'd1, 2);
    check_output("stall_long", 0, 0, 0, 0, 0, 3, 5);
    apply_stimulus(2'd2, 1);
    check_output("stall_exit", 1, 0, 0, 0, 0, 3, 5);

    // Out-of-range value, then an illegal 3->1 step.
    apply_stimulus(2'd2, 4);
    apply_stimulus(2'd3, 1);
    check_output("range", 1, 0, 1, 0, 0, 4, 5);
    apply_stimulus(2'd1, 1);
    check_output("range_exit", 1, 0, 1, 0, 0, 5, 5);

    // Relock, then 0->2 after 3 clocks: both errors, one increment.
    apply_stimulus(2'd1, 4);
    apply_stimulus(2'd2, 1);
    apply_stimulus(2'd2, 4);
    apply_stimulus(2'd0, 1);
    check_output("relock2", 1, 0, 0, 0, 1, 5, 5);
    apply_stimulus(2'd0, 2);
    apply_stimulus(2'd2, 1);
    check_output("both", 1, 0, 1, 1, 0, 6, 5);

    // Same double error with clr_err on the same edge.
    apply_stimulus(2'd2, 4);
    apply_stimulus(2'd0, 1);
    apply_stimulus(2'd0, 4);
    apply_stimulus(2'd1, 1);
    check_output("relock3", 1, 0, 0, 0, 1, 6, 5);
    apply_stimulus(2'd1, 2);
    clr_err = 1'b1;
    apply_stimulus(2'd0, 1);
    clr_err = 1'b0;
    check_output("both_clr", 1, 0, 1, 1, 0, 0, 5);

    // Saturation: 260 illegal steps alternating 3 and 1 while in IDLE.
    for (int i = 0; i < 260; i++) begin
      apply_stimulus((i % 2 == 0) ? 2'd3 : 2'd1, 1);
      if (i == 253) check_output("sat_254", 1, 0, 1, 0, 0, 254, 5);
    end
    check_output("sat", 1, 0, 1, 0, 0, 255, 5);

    // Lock again, then a one-clock reset mid-operation.
    apply_stimulus(2'd1, 4);
    apply_stimulus(2'd2, 1);
    apply_stimulus(2'd2, 4);
    apply_stimulus(2'd0, 1);
    check_output("prereset", 1, 0, 0, 0, 1, 255, 5);
    apply_stimulus(2'd0, 2);
    rst = 1'b0;
    apply_stimulus(2'd1, 1);
    check_output("midreset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    apply_stimulus(2'd1, 1);
    check_output("post_reset", 1, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
